// File: rtl/serial_collector_pkg.sv
// Shared parameters, types and sign-extension helpers for the Stripes
// serial collector (bit-serial array results back to parallel memory rows).
package stripes_pkg;
  localparam int WL              = 16;
  localparam int WORDS_PER_BRICK = 16;
  localparam int BRICKS_PER_ROW  = 16;
  localparam int PREC_BITS       = 5;
  localparam int SW              = WORDS_PER_BRICK * BRICKS_PER_ROW;
  localparam int RL              = WL * SW;
  localparam int IDX_BITS        = $clog2(WL);

  typedef logic [WL-1:0]        word_t;
  typedef logic [PREC_BITS-1:0] prec_t;

  typedef enum logic {ST_FILL, ST_HELD} fill_state_e;

  // Precisions of zero or beyond the word length mean a full-width group.
  function automatic prec_t normPrec(input prec_t p);
    if (p == '0 || p > prec_t'(WL)) return prec_t'(WL);
    return p;
  endfunction

  function automatic word_t sext(input word_t word, input prec_t p);
    word_t                res;
    logic [IDX_BITS-1:0]  signIdx;
    signIdx = IDX_BITS'(p - prec_t'(1));
    for (int i = 0; i < WL; i++) begin
      res[i] = (i < int'(p)) ? word[i] : word[signIdx];
    end
    return res;
  endfunction
endpackage

// File: rtl/serial_collector_if.sv
// Serial beat input and assembled-row output bundle of the collector.
interface serial_collector_if;
  import stripes_pkg::*;

  logic          i_valid;
  logic [SW-1:0] i_stream;
  prec_t         i_prec;
  logic          o_ready;
  logic [RL-1:0] o_row;
  logic          o_row_valid;
  logic          i_row_ready;

  modport master (
    output i_valid, i_stream, i_prec, i_row_ready,
    input  o_ready, o_row, o_row_valid
  );

  modport slave (
    input  i_valid, i_stream, i_prec, i_row_ready,
    output o_ready, o_row, o_row_valid
  );
endinterface

// File: rtl/serial_collector_lane.sv
// One serial lane: MSB-first shift register with a sign-extended word view.
module collector_lane
  import stripes_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  shift_en_i,
  input  logic  bit_i,
  input  prec_t p_reg_i,
  output word_t word_o
);
  word_t fill_q, fill_d;

  // The word view includes the incoming bit so a completing beat is captured directly.
  always_comb begin
    fill_d = fill_q;
    if (shift_en_i) fill_d = {fill_q[WL-2:0], bit_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  assign word_o = sext(fill_d, p_reg_i);
endmodule

// File: rtl/serial_collector.sv
// Bit-serial to bit-parallel collector: SW lanes feed a double-buffered row
// (fill side plus output register) drained through a valid/ready handshake.
module serial_collector
  import stripes_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  serial_collector_if.slave bus
);
  fill_state_e   state_q, state_d;
  prec_t         cnt_q, cnt_d;
  prec_t         pReg_q, pReg_d;
  prec_t         pEff;
  logic [RL-1:0] row_q, row_d;
  logic [RL-1:0] rowAsm;
  logic          rowValid_q, rowValid_d;
  logic          ready, accept, lastBeat, bufFree, load;

  assign ready           = (state_q == ST_FILL);
  assign bus.o_ready     = ready;
  assign bus.o_row       = row_q;
  assign bus.o_row_valid = rowValid_q;

  assign accept   = bus.i_valid && ready;
  // On the first beat the group precision comes straight from the input.
  assign pEff     = (accept && cnt_q == '0) ? normPrec(bus.i_prec) : pReg_q;
  assign lastBeat = accept && (cnt_q == pEff - prec_t'(1));
  assign bufFree  = !rowValid_q || bus.i_row_ready;

  for (genvar l = 0; l < SW; l++) begin : g_lane
    collector_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en_i (accept),
      .bit_i      (bus.i_stream[l]),
      .p_reg_i    (pEff),
      .word_o     (rowAsm[l*WL +: WL])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pReg_d  = pReg_q;
    load    = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          pReg_d = pEff;
          if (lastBeat) begin
            cnt_d = '0;
            if (bufFree) load = 1'b1;
            else         state_d = ST_HELD;
          end else begin
            cnt_d = cnt_q + prec_t'(1);
          end
        end
      end
      ST_HELD: begin
        if (bufFree) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // A load while the old row drains keeps valid high for back-to-back rows.
  always_comb begin
    row_d      = load ? rowAsm : row_q;
    rowValid_d = load || (rowValid_q && !bus.i_row_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      pReg_q     <= prec_t'(WL);
      row_q      <= '0;
      rowValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pReg_q     <= pReg_d;
      row_q      <= row_d;
      rowValid_q <= rowValid_d;
    end
  end
endmodule

// File: tb/tb_serial_collector.sv
// Self-checking bench for serial_collector: a row-queue model checked every
// cycle, plus directed vectors with hand-computed words.
module tb_serial_collector;
  import stripes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic started = 1'b0;

  serial_collector_if bus ();

  serial_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: completed rows waiting to leave (head is the visible output row).
  logic [RL-1:0] rowQ[$];
  int            acc[SW];
  int            beatCnt = 0;
  int            modelP = WL;

  function automatic int normP(input int p);
    return (p == 0 || p > WL) ? WL : p;
  endfunction

  function automatic logic [WL-1:0] signedWord(input int bits, input int p);
    int v;
    v = bits & ((1 << p) - 1);
    if (v >= (1 << (p - 1))) v = v - (1 << p);
    return v[WL-1:0];
  endfunction

  task automatic modelStep();
    logic          readyNow;
    logic [RL-1:0] newRow;
    if (!rst_n) begin
      rowQ.delete();
      beatCnt = 0;
      for (int l = 0; l < SW; l++) acc[l] = 0;
      started = 1'b1;
    end else begin
      readyNow = (rowQ.size() < 2);
      if (rowQ.size() > 0 && bus.i_row_ready) void'(rowQ.pop_front());
      if (bus.i_valid && readyNow) begin
        if (beatCnt == 0) begin
          modelP = normP(int'(bus.i_prec));
          for (int l = 0; l < SW; l++) acc[l] = 0;
        end
        for (int l = 0; l < SW; l++) acc[l] = (acc[l] << 1) | int'(bus.i_stream[l]);
        beatCnt++;
        if (beatCnt == modelP) begin
          for (int l = 0; l < SW; l++) newRow[l*WL +: WL] = signedWord(acc[l], modelP);
          rowQ.push_back(newRow);
          beatCnt = 0;
        end
      end
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [WL-1:0] actual, input logic [WL-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkRow(input logic [RL-1:0] actual, input logic [RL-1:0] expected);
    int bad;
    checks++;
    if (actual !== expected) begin
      bad = 0;
      for (int l = SW - 1; l >= 0; l--)
        if (actual[l*WL +: WL] !== expected[l*WL +: WL]) bad = l;
      failures++;
      $display("[TB] FAIL o_row lane %0d: got %h expected %h at %0t",
               bad, actual[bad*WL +: WL], expected[bad*WL +: WL], $time);
    end
  endtask

  task automatic compareStep();
    if (started) begin
      checkFlag("o_ready", bus.o_ready, rowQ.size() < 2);
      checkFlag("o_row_valid", bus.o_row_valid, rowQ.size() > 0);
      if (rowQ.size() > 0) checkRow(bus.o_row, rowQ[0]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    compareStep();
  end

  function automatic logic [WL-1:0] rowWord(input int l);
    return bus.o_row[l*WL +: WL];
  endfunction

  function automatic logic [SW-1:0] mk(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                       input logic [WL-1:0] c, input logic [WL-1:0] d,
                                       input int idx);
    logic [SW-1:0] s;
    s = '0;
    s[0] = a[idx];
    s[1] = b[idx];
    s[2] = c[idx];
    s[3] = d[idx];
    return s;
  endfunction

  task automatic applyStimulus(input logic v, input logic [SW-1:0] s, input prec_t p, input logic rr);
    @(negedge clk);
    bus.i_valid     = v;
    bus.i_stream    = s;
    bus.i_prec      = p;
    bus.i_row_ready = rr;
  endtask

  task automatic idle(input logic rr);
    applyStimulus(1'b0, '0, 5'd0, rr);
  endtask

  task automatic printSummary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WL-1:0] b;
    bus.i_valid     = 1'b0;
    bus.i_stream    = '0;
    bus.i_prec      = '0;
    bus.i_row_ready = 1'b1;
    rst_n           = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkFlag("reset o_row_valid", bus.o_row_valid, 1'b0);
    checkFlag("reset o_ready", bus.o_ready, 1'b1);
    checkOutput("reset word0", rowWord(0), 16'h0000);
    rst_n = 1'b1;

    $display("[TB] p=16 four-lane group");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, mk(16'h8001, 16'h7FFE, 16'hFFFF, 16'h0000, 15 - k), 5'd16, 1'b1);
      if (k == 15) checkFlag("p16 not early", bus.o_row_valid, 1'b0);
    end
    idle(1'b1);
    checkFlag("p16 valid", bus.o_row_valid, 1'b1);
    checkOutput("p16 word0", rowWord(0), 16'h8001);
    checkOutput("p16 word1", rowWord(1), 16'h7FFE);
    checkOutput("p16 word2", rowWord(2), 16'hFFFF);
    checkOutput("p16 word3", rowWord(3), 16'h0000);
    idle(1'b1);
    checkFlag("p16 drained", bus.o_row_valid, 1'b0);

    $display("[TB] p=4 sign extension");
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, mk(16'h000B, 16'h0007, 16'h0000, 16'h0000, 3 - k), 5'd4, 1'b1);
    idle(1'b1);
    checkOutput("p4 word0", rowWord(0), 16'hFFFB);
    checkOutput("p4 word1", rowWord(1), 16'h0007);
    checkOutput("p4 word2 no residue", rowWord(2), 16'h0000);
    idle(1'b1);

    $display("[TB] p=1 streaming");
    for (int k = 0; k < 8; k++) begin
      b = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      applyStimulus(1'b1, mk(b, 16'h0000, 16'h0000, 16'h0000, 0), 5'd1, 1'b1);
      if (k > 0) begin
        checkFlag("p1 valid", bus.o_row_valid, 1'b1);
        checkOutput("p1 word0", rowWord(0), ((k - 1) % 2 == 0) ? 16'hFFFF : 16'h0000);
      end
    end
    idle(1'b1);
    checkOutput("p1 last word0", rowWord(0), 16'h0000);
    idle(1'b1);

    $display("[TB] backpressure p=2");
    for (int k = 0; k < 2; k++)
      applyStimulus(1'b1, mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1 - k), 5'd2, 1'b0);
    for (int k = 0; k < 2; k++)
      applyStimulus(1'b1, mk(16'h0002, 16'h0000, 16'h0000, 16'h0000, 1 - k), 5'd2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, mk(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0), 5'd1, 1'b0);
      checkFlag("held o_ready", bus.o_ready, 1'b0);
      checkOutput("held rowA word0", rowWord(0), 16'h0001);
    end
    idle(1'b1);
    checkOutput("rowA still", rowWord(0), 16'h0001);
    idle(1'b0);
    checkFlag("rowB valid", bus.o_row_valid, 1'b1);
    checkOutput("rowB word0", rowWord(0), 16'hFFFE);
    checkFlag("rowB o_ready", bus.o_ready, 1'b1);
    idle(1'b0);
    checkOutput("rowB holds", rowWord(0), 16'hFFFE);
    idle(1'b1);
    idle(1'b1);
    checkFlag("rowB drained", bus.o_row_valid, 1'b0);

    $display("[TB] out-of-range precision");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, mk(16'h1234, 16'hABCD, 16'h0000, 16'h0000, 15 - k),
                    (k == 0) ? 5'd0 : 5'd3, 1'b1);
      if (k == 15) checkFlag("prec0 not early", bus.o_row_valid, 1'b0);
    end
    idle(1'b1);
    checkFlag("prec0 valid", bus.o_row_valid, 1'b1);
    checkOutput("prec0 word0", rowWord(0), 16'h1234);
    checkOutput("prec0 word1", rowWord(1), 16'hABCD);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, mk(16'hF00F, 16'h0000, 16'h0000, 16'h0000, 15 - k),
                    (k == 0) ? 5'd20 : 5'd2, 1'b1);
      if (k == 15) checkFlag("prec20 not early", bus.o_row_valid, 1'b0);
    end
    idle(1'b1);
    checkOutput("prec20 word0", rowWord(0), 16'hF00F);
    idle(1'b1);

    $display("[TB] reset mid-group with row pending");
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, mk(16'h005A, 16'h0000, 16'h0000, 16'h0000, 7 - k), 5'd8, 1'b0);
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, mk(16'h00C3, 16'h00FF, 16'h0000, 16'h0000, 7 - k), 5'd8, 1'b0);
    idle(1'b0);
    checkFlag("pending before reset", bus.o_row_valid, 1'b1);
    rst_n = 1'b0;
    idle(1'b1);
    checkFlag("after reset o_row_valid", bus.o_row_valid, 1'b0);
    checkFlag("after reset o_ready", bus.o_ready, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, mk(16'h0096, 16'h0035, 16'h0000, 16'h0000, 7 - k), 5'd8, 1'b1);
    idle(1'b1);
    checkFlag("fresh valid", bus.o_row_valid, 1'b1);
    checkOutput("fresh word0", rowWord(0), 16'hFF96);
    checkOutput("fresh word1", rowWord(1), 16'h0035);
    idle(1'b1);
    idle(1'b1);

    printSummary();
    $finish;
  end
endmodule

// File: doc/serial_collector.md
# serial_collector

Bit-serial to bit-parallel collector, the return path of the Stripes dispatcher. It accepts one bit per lane per cycle from the serial processing array, MSB first, over a per-group precision of 1..WL bits. It reassembles each lane into a sign-extended WL-bit word and presents complete rows (BRICKS_PER_ROW bricks of WORDS_PER_BRICK words) to the memory write port through a valid/ready handshake. A double buffer (fill plus output) lets one row collect while the previous row drains.

## Interface
- WL, 16, word length in bits
- WORDS_PER_BRICK, 16, words per brick
- BRICKS_PER_ROW, 16, bricks per memory row
- PREC_BITS, 5, width of precision field; must hold WL
- SW (derived), WORDS_PER_BRICK*BRICKS_PER_ROW, number of serial lanes
- RL (derived), WL*SW, row width in bits
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- i_valid  in  1  serial beat valid
- i_stream  in  SW  one bit per lane; lane l builds word l
- i_prec  in  PREC_BITS  group precision p; sampled on the first accepted beat of a group
- o_ready  out  1  collector accepts a beat this cycle
- o_row  out  RL  assembled row; word l at o_row[l*WL +: WL]
- o_row_valid  out  1  o_row holds a complete row
- i_row_ready  in  1  memory side accepts o_row

## Operation
- Beat accepted when i_valid && o_ready. Lane l shifts its bit into the LSB of fill word l: fill = {fill[WL-2:0], bit}.
- Bit counter cnt (0..WL-1) counts accepted beats in the group. On the first beat (cnt==0), p_reg <= i_prec. i_prec==0 or i_prec>WL is treated as WL.
- Group completes on the beat where cnt==p_reg-1. For p==1 the first beat is also the last.
- On completion, each word equals the low p collected bits sign-extended from bit p-1 to WL bits.
- Fill-side FSM:
  - FILL: o_ready=1.
  - On a completing beat, if the output buffer is free, the row transfers and the FSM stays in FILL with cnt<=0. Otherwise go to HELD.
  - HELD: o_ready=0. Transfer when the output buffer is free, then go to FILL with cnt<=0.
- The output buffer is free when !o_row_valid, or when o_row_valid && i_row_ready in the same cycle (drain and refill the same cycle; o_row_valid stays 1).
- Output handshake: o_row and o_row_valid hold unchanged while o_row_valid && !i_row_ready. o_row_valid falls after acceptance unless a new row transfers in the same cycle.
- i_valid is ignored when o_ready==0. i_stream and i_prec are don't-care when not accepted. Gaps in i_valid mid-group only pause collection.

## Timing
- Reset values: o_row_valid=0, o_row=0, FSM=FILL (so o_ready=1 in the first cycle after reset), cnt=0, fill words=0.
- Reset mid-group or with a row pending discards the partial group and the pending row. No spurious o_row_valid.
- Latency: completing beat accepted at edge t gives o_row_valid=1 from t+1.
- Throughput: one row per p accepted beats, sustained at p=1 when i_row_ready stays high.
- o_ready is combinational from FSM state only, with no path from i_valid. o_row is registered.
- Backpressure depth: one row in the output buffer plus one complete row in HELD. Further beats stall.

## Structure
- Shared package stripes_pkg holds:
  - WL, WORDS_PER_BRICK, BRICKS_PER_ROW, PREC_BITS
  - derived SW and RL
  - sign-extension function sext(word, p)
- Sub-module collector_lane: one per lane, generated SW times. Contains the shift register and sign-extension output, and takes shift_en and p_reg.
- Top level owns cnt, p_reg, the FSM and the output buffer register.

## Test plan
- Reset, p=16, lanes 0..3 send 0x8001, 0x7FFE, 0xFFFF, 0x0000 MSB-first over 16 beats with i_row_ready=1. Expect o_row_valid one cycle after beat 16, words 0..3 matching, and o_ready=1 throughout.
- p=4, lane 0 bits 1,0,1,1 and lane 1 bits 0,1,1,1. Expect word0=0xFFFB and word1=0x0007.
- p=1 streaming 8 beats with i_row_ready=1, lane 0 alternating 1,0,…. Expect o_row_valid high every cycle after the first, word0 alternating 0xFFFF/0x0000, and o_ready never low.
- Backpressure: p=2 with i_row_ready=0. Row A becomes valid, row B completes into HELD, o_ready=0. Row A holds stable. Raising i_row_ready for 1 cycle makes row B appear next cycle and o_ready return to 1.
- i_prec=0 and i_prec=20 each collect 16 beats before o_row_valid. Changing i_prec mid-group has no effect.
- Assert rst_n=0 after 5 of 8 beats with a row pending. Next cycle o_row_valid=0 and o_ready=1, and a fresh p=8 group yields correct words with no residue.
